// File: rtl/axil_master_if.sv
// rtl/axil_master_if.sv - command/response and AXI-Lite bus bundle for axil_master
interface axil_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // command side
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;

  // completion side
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // AXI-Lite write channels
  logic [ADDR_WIDTH-1:0] m_axil_awaddr;
  logic [2:0]            m_axil_awprot;
  logic                  m_axil_awvalid;
  logic                  m_axil_awready;
  logic [DATA_WIDTH-1:0] m_axil_wdata;
  logic [STRB_WIDTH-1:0] m_axil_wstrb;
  logic                  m_axil_wvalid;
  logic                  m_axil_wready;
  logic [1:0]            m_axil_bresp;
  logic                  m_axil_bvalid;
  logic                  m_axil_bready;

  // AXI-Lite read channels
  logic [ADDR_WIDTH-1:0] m_axil_araddr;
  logic [2:0]            m_axil_arprot;
  logic                  m_axil_arvalid;
  logic                  m_axil_arready;
  logic [DATA_WIDTH-1:0] m_axil_rdata;
  logic [1:0]            m_axil_rresp;
  logic                  m_axil_rvalid;
  logic                  m_axil_rready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    input  m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid,
    output m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    input  m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output m_axil_rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid,
    input  m_axil_bready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  m_axil_rready
  );
endinterface

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding command to AXI-Lite master
module axil_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          aclk,
  input  logic          areset,
  axil_master_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  // which of AW / W have already handshaken in the current write
  logic                  r_aw_done;
  logic                  r_w_done;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_req_ready;
  logic                  w_awvalid;
  logic                  w_wvalid;
  logic                  w_bready;
  logic                  w_arvalid;
  logic                  w_rready;

  logic                  w_req_fire;
  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_b_fire;
  logic                  w_ar_fire;
  logic                  w_r_fire;
  logic                  w_aw_all;
  logic                  w_w_all;

  assign w_req_fire = bus.req_valid && w_req_ready;
  assign w_aw_fire  = w_awvalid && bus.m_axil_awready;
  assign w_w_fire   = w_wvalid && bus.m_axil_wready;
  assign w_b_fire   = w_bready && bus.m_axil_bvalid;
  assign w_ar_fire  = w_arvalid && bus.m_axil_arready;
  assign w_r_fire   = w_rready && bus.m_axil_rvalid;

  // a channel counts as finished if it completed earlier or completes now
  assign w_aw_all = r_aw_done || w_aw_fire;
  assign w_w_all  = r_w_done || w_w_fire;

  // state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_req_fire) w_next_state = bus.req_write ? S_WADDR : S_RADDR;
      S_WADDR: if (w_aw_all && w_w_all) w_next_state = S_WRESP;
      S_WRESP: if (w_b_fire) w_next_state = S_IDLE;
      S_RADDR: if (w_ar_fire) w_next_state = S_RDATA;
      S_RDATA: if (w_r_fire) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // handshake outputs decoded from registered state only, never from AXI readies
  always_comb begin
    w_req_ready = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      S_IDLE:  w_req_ready = !areset;
      S_WADDR: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
      end
      S_WRESP: w_bready  = 1'b1;
      S_RADDR: w_arvalid = 1'b1;
      S_RDATA: w_rready  = 1'b1;
      default: w_req_ready = 1'b0;
    endcase
  end

  // latch the command payload and track per-channel write progress
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_req_fire) begin
      r_addr    <= bus.req_addr;
      r_wdata   <= bus.req_wdata;
      r_wstrb   <= bus.req_wstrb;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == S_WADDR) begin
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_w_fire)  r_w_done  <= 1'b1;
    end
  end

  // completion pulse; data and error hold until the next completion
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_b_fire || w_r_fire;
      if (w_b_fire) begin
        r_rsp_err   <= (bus.m_axil_bresp != 2'b00);
        r_rsp_rdata <= '0;
      end else if (w_r_fire) begin
        r_rsp_err   <= (bus.m_axil_rresp != 2'b00);
        r_rsp_rdata <= bus.m_axil_rdata;
      end
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_err        = r_rsp_err;
  assign bus.rsp_rdata      = r_rsp_rdata;

  assign bus.m_axil_awaddr  = r_addr;
  assign bus.m_axil_awprot  = 3'b000;
  assign bus.m_axil_awvalid = w_awvalid;
  assign bus.m_axil_wdata   = r_wdata;
  assign bus.m_axil_wstrb   = r_wstrb;
  assign bus.m_axil_wvalid  = w_wvalid;
  assign bus.m_axil_bready  = w_bready;

  assign bus.m_axil_araddr  = r_addr;
  assign bus.m_axil_arprot  = 3'b000;
  assign bus.m_axil_arvalid = w_arvalid;
  assign bus.m_axil_rready  = w_rready;
endmodule

// File: tb/tb_axil_master.sv
// tb/tb_axil_master.sv - scoreboard bench for axil_master
module tb_axil_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk;
  logic areset;

  axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_count = 0;

  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  int aw_cyc = 0, w_cyc = 0, aw_first = 0, w_first = 0;
  logic [31:0] hs_awaddr, hs_wdata, hs_araddr;
  logic [3:0]  hs_wstrb;

  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [31:0] p_awaddr, p_wdata;
  logic [3:0]  p_wstrb;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // slave model: each channel answers with its configured wait count
  initial begin
    bus.m_axil_awready = 1'b0;
    tick();
    forever begin
      if (bus.m_axil_awvalid) begin
        repeat (aw_delay) tick();
        bus.m_axil_awready = 1'b1;
        tick();
        bus.m_axil_awready = 1'b0;
      end else tick();
    end
  end

  initial begin
    bus.m_axil_wready = 1'b0;
    tick();
    forever begin
      if (bus.m_axil_wvalid) begin
        repeat (w_delay) tick();
        bus.m_axil_wready = 1'b1;
        tick();
        bus.m_axil_wready = 1'b0;
      end else tick();
    end
  end

  initial begin
    bus.m_axil_bvalid = 1'b0;
    bus.m_axil_bresp  = 2'b00;
    tick();
    forever begin
      if (bus.m_axil_bready) begin
        repeat (b_delay) tick();
        bus.m_axil_bvalid = 1'b1;
        bus.m_axil_bresp  = bresp_cfg;
        tick();
        bus.m_axil_bvalid = 1'b0;
        bus.m_axil_bresp  = 2'b00;
      end else tick();
    end
  end

  initial begin
    bus.m_axil_arready = 1'b0;
    tick();
    forever begin
      if (bus.m_axil_arvalid) begin
        repeat (ar_delay) tick();
        bus.m_axil_arready = 1'b1;
        tick();
        bus.m_axil_arready = 1'b0;
      end else tick();
    end
  end

  initial begin
    bus.m_axil_rvalid = 1'b0;
    bus.m_axil_rdata  = 32'h0;
    bus.m_axil_rresp  = 2'b00;
    tick();
    forever begin
      if (bus.m_axil_rready) begin
        repeat (r_delay) tick();
        bus.m_axil_rvalid = 1'b1;
        bus.m_axil_rdata  = rdata_cfg;
        bus.m_axil_rresp  = rresp_cfg;
        tick();
        bus.m_axil_rvalid = 1'b0;
        bus.m_axil_rdata  = 32'h0;
        bus.m_axil_rresp  = 2'b00;
      end else tick();
    end
  end

  // protocol watcher: valid must hold with stable payload until ready
  always @(negedge aclk) begin
    if (!areset) begin
      if (p_awv && !p_awr) begin
        check("awvalid_hold", bus.m_axil_awvalid, 1);
        check("awaddr_stable", bus.m_axil_awaddr, p_awaddr);
      end
      if (p_wv && !p_wr) begin
        check("wvalid_hold", bus.m_axil_wvalid, 1);
        check("wdata_stable", {bus.m_axil_wstrb, bus.m_axil_wdata}, {p_wstrb, p_wdata});
      end
      if (bus.m_axil_awvalid) begin
        if (aw_cyc == 0) aw_first = cyc;
        aw_cyc++;
        if (bus.m_axil_awready) hs_awaddr = bus.m_axil_awaddr;
      end
      if (bus.m_axil_wvalid) begin
        if (w_cyc == 0) w_first = cyc;
        w_cyc++;
        if (bus.m_axil_wready) begin
          hs_wdata = bus.m_axil_wdata;
          hs_wstrb = bus.m_axil_wstrb;
        end
      end
      if (bus.m_axil_arvalid && bus.m_axil_arready) hs_araddr = bus.m_axil_araddr;
    end
    p_awv    = bus.m_axil_awvalid;
    p_awr    = bus.m_axil_awready;
    p_awaddr = bus.m_axil_awaddr;
    p_wv     = bus.m_axil_wvalid;
    p_wr     = bus.m_axil_wready;
    p_wdata  = bus.m_axil_wdata;
    p_wstrb  = bus.m_axil_wstrb;
  end

  // response monitor: pops the scoreboard on every completion pulse
  always @(negedge aclk) begin
    if (bus.rsp_valid) begin
      rsp_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", bus.rsp_err, e.err);
        if (e.lat >= 0) check("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                        input int lat, input bit expect_rsp, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge aclk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = strb;
    while (!bus.req_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout actual=0 required=1");
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (expect_rsp) sb.push_back('{exp_rdata, exp_err, cyc, lat});
    @(posedge aclk);
    #1;
    bus.req_valid = 1'b0;
    aw_cyc = 0;
    w_cyc  = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
    @(negedge aclk);
  endtask

  initial begin
    int a1, a2, n;
    areset        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_wstrb = 4'h0;
    repeat (3) @(negedge aclk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid,
                         bus.m_axil_bready, bus.m_axil_rready, bus.rsp_valid, bus.rsp_err}, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("idle_req_ready", bus.req_ready, 1);
    check("prot_const", {bus.m_axil_awprot, bus.m_axil_arprot}, 0);

    // basic write, always-ready slave
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 3, 1'b1, a1);
    wait_done();
    check("w1_aw_cycles", aw_cyc, 1);
    check("w1_w_cycles", w_cyc, 1);
    check("w1_aw_w_same_cycle", aw_first, w_first);
    check("w1_aw_first", aw_first, a1 + 1);
    check("w1_awaddr", hs_awaddr, 32'h0000_0010);
    check("w1_wdata", hs_wdata, 32'hDEAD_BEEF);
    check("w1_wstrb", hs_wstrb, 4'hF);

    // AW delayed 4 waits, W immediate
    aw_delay = 4;
    do_req(1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 4'h3, 32'h0, 1'b0, 7, 1'b1, a1);
    wait_done();
    aw_delay = 0;
    check("w2_aw_cycles", aw_cyc, 5);
    check("w2_w_cycles", w_cyc, 1);
    check("w2_awaddr", hs_awaddr, 32'h0000_0044);
    check("w2_wstrb", hs_wstrb, 4'h3);

    // W delayed 3 waits, AW immediate
    w_delay = 3;
    do_req(1'b1, 32'h0000_0048, 32'h0BAD_F00D, 4'hC, 32'h0, 1'b0, 6, 1'b1, a1);
    wait_done();
    w_delay = 0;
    check("w3_aw_cycles", aw_cyc, 1);
    check("w3_w_cycles", w_cyc, 4);
    check("w3_wdata", hs_wdata, 32'h0BAD_F00D);

    // back-to-back write then read
    rdata_cfg = 32'h1111_2222;
    do_req(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, 3, 1'b1, a1);
    do_req(1'b0, 32'h0000_0054, 32'h0, 4'h0, 32'h1111_2222, 1'b0, 3, 1'b1, a2);
    wait_done();
    check("b2b_accept_gap", a2 - a1, 3);
    check("b2b_araddr", hs_araddr, 32'h0000_0054);

    // read with SLVERR, then clean write, then write with DECERR
    rresp_cfg = 2'b10;
    rdata_cfg = 32'hCAFE_F00D;
    do_req(1'b0, 32'h0000_0060, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 3, 1'b1, a1);
    wait_done();
    rresp_cfg = 2'b00;
    do_req(1'b1, 32'h0000_0064, 32'h0000_0001, 4'h1, 32'h0, 1'b0, 3, 1'b1, a1);
    wait_done();
    bresp_cfg = 2'b11;
    do_req(1'b1, 32'h0000_0068, 32'h0000_0002, 4'h2, 32'h0, 1'b1, 3, 1'b1, a1);
    wait_done();
    bresp_cfg = 2'b00;

    // read with 5 wait cycles on R
    r_delay   = 5;
    rdata_cfg = 32'h1234_5678;
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 8, 1'b1, a1);
    wait_done();
    repeat (2) @(negedge aclk);
    check("rsp_rdata_hold", bus.rsp_rdata, 32'h1234_5678);
    check("rsp_valid_single", bus.rsp_valid, 0);

    // reset while waiting in RDATA
    r_delay   = 20;
    rdata_cfg = 32'hFFFF_0000;
    do_req(1'b0, 32'h0000_0070, 32'h0, 4'h0, 32'h0, 1'b0, -1, 1'b0, a1);
    n = 0;
    while (!bus.m_axil_rready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("rdata_state_reached", bus.m_axil_rready, 1);
    areset = 1'b1;
    #1;
    check("mid_rst_handshakes", {bus.req_ready, bus.m_axil_arvalid, bus.m_axil_rready,
                                 bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready}, 0);
    check("mid_rst_rsp", {bus.rsp_valid, bus.rsp_err}, 0);
    check("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
    check("mid_rst_payload", bus.m_axil_araddr, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_req_ready", bus.req_ready, 1);
    repeat (30) @(negedge aclk);
    check("total_responses", rsp_count, 9);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
